// File: rtl/r4_butterfly_pipe.sv
// Two-stage pipelined complex radix-4 butterfly with per-transaction forward/inverse
// selection, optional divide-by-4 rounding and a valid/ready handshake with backpressure.
module r4_butterfly_pipe #(
    parameter  int DW    = 16,
    parameter  int SCALE = 0,
    localparam int OW    = (SCALE != 0) ? DW : DW + 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_inv,
    input  logic [4*DW-1:0] x_re,
    input  logic [4*DW-1:0] x_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*OW-1:0] y_re,
    output logic [4*OW-1:0] y_im
);

    localparam int W1 = DW + 1;
    localparam int W2 = DW + 2;

    logic signed [DW-1:0] w_xr [4];
    logic signed [DW-1:0] w_xi [4];

    logic signed [W1-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [W1-1:0] w_c_re, w_c_im, w_d_re, w_d_im;

    logic                 r_v1;
    logic                 r_inv1;
    logic signed [W1-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
    logic signed [W1-1:0] r_c_re, r_c_im, r_d_re, r_d_im;

    logic signed [W2-1:0] w_p_re, w_p_im, w_q_re, w_q_im;
    logic signed [W2-1:0] w_r_re, w_r_im, w_s_re, w_s_im;
    logic signed [W2-1:0] w_full_re [4];
    logic signed [W2-1:0] w_full_im [4];
    logic [4*OW-1:0]      w_y_re;
    logic [4*OW-1:0]      w_y_im;

    logic                 r_v2;
    logic [4*OW-1:0]      r_y_re;
    logic [4*OW-1:0]      r_y_im;

    logic                 w_s1_en;
    logic                 w_s2_en;

    // Round-half-up divide by 4; the extra bit keeps v+2 from wrapping before the shift.
    function automatic logic [OW-1:0] f_scale(input logic signed [W2-1:0] v);
        logic signed [W2:0] w_sum;
        logic signed [W2:0] w_sh;
        w_sum = (W2+1)'(v) + (W2+1)'(2);
        w_sh  = w_sum >>> 2;
        if (SCALE != 0) return OW'(w_sh);
        else            return OW'(v);
    endfunction

    // A stage may load when it is empty or when its content moves on this cycle.
    assign w_s2_en  = ~r_v2 | out_ready;
    assign w_s1_en  = ~r_v1 | w_s2_en;
    assign in_ready = w_s1_en;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_xr[i] = x_re[i*DW +: DW];
            w_xi[i] = x_im[i*DW +: DW];
        end
    end

    assign w_a_re = W1'(w_xr[0]) + W1'(w_xr[2]);
    assign w_a_im = W1'(w_xi[0]) + W1'(w_xi[2]);
    assign w_b_re = W1'(w_xr[0]) - W1'(w_xr[2]);
    assign w_b_im = W1'(w_xi[0]) - W1'(w_xi[2]);
    assign w_c_re = W1'(w_xr[1]) + W1'(w_xr[3]);
    assign w_c_im = W1'(w_xi[1]) + W1'(w_xi[3]);
    assign w_d_re = W1'(w_xr[1]) - W1'(w_xr[3]);
    assign w_d_im = W1'(w_xi[1]) - W1'(w_xi[3]);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are cleared too, so the outputs read zero straight out of reset.
            r_v1   <= 1'b0;
            r_inv1 <= 1'b0;
            r_a_re <= '0;
            r_a_im <= '0;
            r_b_re <= '0;
            r_b_im <= '0;
            r_c_re <= '0;
            r_c_im <= '0;
            r_d_re <= '0;
            r_d_im <= '0;
        end else if (w_s1_en) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_inv1 <= in_inv;
                r_a_re <= w_a_re;
                r_a_im <= w_a_im;
                r_b_re <= w_b_re;
                r_b_im <= w_b_im;
                r_c_re <= w_c_re;
                r_c_im <= w_c_im;
                r_d_re <= w_d_re;
                r_d_im <= w_d_im;
            end
        end
    end

    assign w_p_re = W2'(r_a_re) + W2'(r_c_re);
    assign w_p_im = W2'(r_a_im) + W2'(r_c_im);
    assign w_q_re = W2'(r_a_re) - W2'(r_c_re);
    assign w_q_im = W2'(r_a_im) - W2'(r_c_im);
    // r = b - j*d, s = b + j*d
    assign w_r_re = W2'(r_b_re) + W2'(r_d_im);
    assign w_r_im = W2'(r_b_im) - W2'(r_d_re);
    assign w_s_re = W2'(r_b_re) - W2'(r_d_im);
    assign w_s_im = W2'(r_b_im) + W2'(r_d_re);

    always_comb begin
        // NOTE: every output of this block is given a value first, so no latch can be inferred.
        w_y_re = '0;
        w_y_im = '0;
        w_full_re[0] = w_p_re;
        w_full_im[0] = w_p_im;
        w_full_re[2] = w_q_re;
        w_full_im[2] = w_q_im;
        w_full_re[1] = r_inv1 ? w_s_re : w_r_re;
        w_full_im[1] = r_inv1 ? w_s_im : w_r_im;
        w_full_re[3] = r_inv1 ? w_r_re : w_s_re;
        w_full_im[3] = r_inv1 ? w_r_im : w_s_im;
        for (int i = 0; i < 4; i++) begin
            w_y_re[i*OW +: OW] = f_scale(w_full_re[i]);
            w_y_im[i*OW +: OW] = f_scale(w_full_im[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v2   <= 1'b0;
            r_y_re <= '0;
            r_y_im <= '0;
        end else if (w_s2_en) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_y_re <= w_y_re;
                r_y_im <= w_y_im;
            end
        end
    end

    assign out_valid = r_v2;
    assign y_re      = r_y_re;
    assign y_im      = r_y_im;

endmodule

// File: tb/tb_r4_butterfly_pipe.sv
// Self-checking bench: SCALE=0 and SCALE=1 instances driven in lockstep, directed vector
// table, latency/backpressure/reset sequences and a random run against a direct DFT-4 model.
module tb_r4_butterfly_pipe;

    typedef struct packed {
        logic [3:0][17:0] re0;
        logic [3:0][17:0] im0;
        logic [3:0][15:0] re1;
        logic [3:0][15:0] im1;
    } exp_t;

    typedef struct {
        logic             inv;
        logic [3:0][15:0] xr;
        logic [3:0][15:0] xi;
        exp_t             e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_inv;
    logic [63:0] x_re;
    logic [63:0] x_im;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [71:0] y_re0, y_im0;
    logic [63:0] y_re1, y_im1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    exp_t sb[$];

    r4_butterfly_pipe #(.DW(16), .SCALE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_inv(in_inv),
        .x_re(x_re), .x_im(x_im), .out_valid(out_valid0), .out_ready(out_ready),
        .y_re(y_re0), .y_im(y_im0)
    );

    r4_butterfly_pipe #(.DW(16), .SCALE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_inv(in_inv),
        .x_re(x_re), .x_im(x_im), .out_valid(out_valid1), .out_ready(out_ready),
        .y_re(y_re1), .y_im(y_im1)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [3:0][17:0] m18(input int a, input int b, input int c, input int d);
        logic [3:0][17:0] r;
        r[0] = 18'(a); r[1] = 18'(b); r[2] = 18'(c); r[3] = 18'(d);
        return r;
    endfunction

    function automatic logic [3:0][15:0] m16(input int a, input int b, input int c, input int d);
        logic [3:0][15:0] r;
        r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
        return r;
    endfunction

    // Direct DFT-4: y_k = sum x_n * w^(n*k), w = -j (forward) or +j (inverse).
    function automatic exp_t model(input logic [3:0][15:0] xr, input logic [3:0][15:0] xi,
                                   input logic inv);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            int yr = 0;
            int yi = 0;
            int t;
            for (int n = 0; n < 4; n++) begin
                int r = $signed(xr[n]);
                int i = $signed(xi[n]);
                int m = inv ? (n * k) % 4 : (3 * n * k) % 4;
                case (m)
                    0: begin yr += r; yi += i; end
                    1: begin yr -= i; yi += r; end
                    2: begin yr -= r; yi -= i; end
                    default: begin yr += i; yi -= r; end
                endcase
            end
            e.re0[k] = 18'(yr);
            e.im0[k] = 18'(yi);
            t = (yr + 2) >>> 2;
            e.re1[k] = 16'(t);
            t = (yi + 2) >>> 2;
            e.im1[k] = 16'(t);
        end
        return e;
    endfunction

    // One clock: drive at the falling edge, evaluate handshakes 1 ns later.
    task automatic step(input logic v, input logic inv, input logic [3:0][15:0] xr,
                        input logic [3:0][15:0] xi, input logic ordy, input exp_t e,
                        output logic acc);
        exp_t got;
        @(negedge clk);
        in_valid  = v;
        in_inv    = inv;
        x_re      = xr;
        x_im      = xi;
        out_ready = ordy;
        #1;
        acc = v & in_ready0;
        if (acc) sb.push_back(e);
        if (out_valid0 && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious out_valid", 72'(out_valid0), 72'd0);
            end else begin
                got = sb.pop_front();
                n_pops++;
                check("y_re scale0", y_re0, got.re0);
                check("y_im scale0", y_im0, got.im0);
                check("y_re scale1", 72'(y_re1), 72'(got.re1));
                check("y_im scale1", 72'(y_im1), 72'(got.im1));
                check("out_valid scale1", 72'(out_valid1), 72'd1);
            end
        end
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        exp_t z;
        z = '0;
        step(1'b0, 1'b0, '0, '0, ordy, z, acc);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
        check(name, 72'(sb.size()), 72'd0);
    endtask

    task automatic rand_x(output logic [3:0][15:0] xr, output logic [3:0][15:0] xi);
        for (int n = 0; n < 4; n++) begin
            case ($urandom_range(0, 7))
                0:       begin xr[n] = 16'h8000; xi[n] = 16'h7fff; end
                1:       begin xr[n] = 16'h7fff; xi[n] = 16'h8000; end
                default: begin xr[n] = 16'($urandom); xi[n] = 16'($urandom); end
            endcase
        end
    endtask

    vec_t tbl [6];

    initial begin
        logic             acc;
        logic [3:0][15:0] xr, xi;
        logic [71:0]      snap_re, snap_im;
        int               pops0, accs;
        int               sent;

        tbl[0] = '{1'b0, m16(1, 2, 3, 4), m16(0, 0, 0, 0),
                   '{m18(10, -2, -2, -2), m18(0, 2, 0, -2), m16(3, 0, 0, 0), m16(0, 1, 0, 0)}};
        tbl[1] = '{1'b1, m16(1, 2, 3, 4), m16(0, 0, 0, 0),
                   '{m18(10, -2, -2, -2), m18(0, -2, 0, 2), m16(3, 0, 0, 0), m16(0, 0, 0, 1)}};
        tbl[2] = '{1'b0, m16(-32768, -32768, -32768, -32768), m16(0, 0, 0, 0),
                   '{m18(-131072, 0, 0, 0), m18(0, 0, 0, 0), m16(-32768, 0, 0, 0), m16(0, 0, 0, 0)}};
        tbl[3] = '{1'b0, m16(32767, 32767, 32767, 32767), m16(0, 0, 0, 0),
                   '{m18(131068, 0, 0, 0), m18(0, 0, 0, 0), m16(32767, 0, 0, 0), m16(0, 0, 0, 0)}};
        tbl[4] = '{1'b0, m16(2, 0, 0, 0), m16(0, 0, 0, 0),
                   '{m18(2, 2, 2, 2), m18(0, 0, 0, 0), m16(1, 1, 1, 1), m16(0, 0, 0, 0)}};
        tbl[5] = '{1'b1, m16(1, 0, 0, 0), m16(0, 0, 0, 0),
                   '{m18(1, 1, 1, 1), m18(0, 0, 0, 0), m16(0, 0, 0, 0), m16(0, 0, 0, 0)}};

        // Reset state
        reset = 1'b1; in_valid = 1'b0; in_inv = 1'b0; x_re = '0; x_im = '0; out_ready = 1'b1;
        #12;
        check("reset out_valid", 72'(out_valid0), 72'd0);
        check("reset y_re", y_re0, 72'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready after reset", 72'(in_ready0), 72'd1);
        check("in_ready scale1 after reset", 72'(in_ready1), 72'd1);

        // Latency: out_valid appears exactly two cycles after the input transfer
        step(1'b1, tbl[0].inv, tbl[0].xr, tbl[0].xi, 1'b1, tbl[0].e, acc);
        check("latency accept", 72'(acc), 72'd1);
        idle(1'b1);
        check("latency cycle1 out_valid", 72'(out_valid0), 72'd0);
        idle(1'b1);
        check("latency cycle2 out_valid", 72'(out_valid0), 72'd1);
        drain("latency drain");

        // Directed vector table, back to back
        foreach (tbl[i]) step(1'b1, tbl[i].inv, tbl[i].xr, tbl[i].xi, 1'b1, tbl[i].e, acc);
        drain("table drain");

        // Alternating inv, 8 back-to-back transactions: 8 outputs within 10 cycles means no bubbles
        pops0 = n_pops;
        accs  = 0;
        for (int i = 0; i < 10; i++) begin
            rand_x(xr, xi);
            step(i < 8, 1'(i), xr, xi, 1'b1, model(xr, xi, 1'(i)), acc);
            if (acc) accs++;
        end
        check("alternate accepts", 72'(accs), 72'd8);
        check("alternate no bubbles", 72'(n_pops - pops0), 72'd8);

        // Backpressure: out_ready low for cycles 3..7 while streaming 6 transactions
        pops0 = n_pops;
        sent  = 0;
        snap_re = '0;
        snap_im = '0;
        for (int t = 0; t < 40 && (sent < 6 || sb.size() != 0); t++) begin
            logic ordy;
            ordy = !(t >= 3 && t <= 7);
            rand_x(xr, xi);
            step(sent < 6, 1'(t), xr, xi, ordy, model(xr, xi, 1'(t)), acc);
            if (acc) sent++;
            if (t == 3) begin
                snap_re = y_re0;
                snap_im = y_im0;
            end
            if (t >= 3 && t <= 7) begin
                check("stall in_ready", 72'(in_ready0), 72'd0);
                check("stall out_valid", 72'(out_valid0), 72'd1);
                check("stall y_re stable", y_re0, snap_re);
                check("stall y_im stable", y_im0, snap_im);
            end
        end
        check("backpressure delivered", 72'(n_pops - pops0), 72'd6);
        check("backpressure queue empty", 72'(sb.size()), 72'd0);

        // Asynchronous reset with both stages full
        rand_x(xr, xi);
        step(1'b1, 1'b0, xr, xi, 1'b0, model(xr, xi, 1'b0), acc);
        rand_x(xr, xi);
        step(1'b1, 1'b1, xr, xi, 1'b0, model(xr, xi, 1'b1), acc);
        @(negedge clk);
        #1;
        check("pipe full before reset", 72'(in_ready0), 72'd0);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("async reset out_valid", 72'(out_valid0), 72'd0);
        check("async reset y_re", y_re0, 72'd0);
        check("async reset y_im", y_im0, 72'd0);
        check("async reset scale1 y_re", 72'(y_re1), 72'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready after mid reset", 72'(in_ready0), 72'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check("no stale output", 72'(out_valid0), 72'd0);
        end

        // Random traffic with random stalls against the DFT-4 model
        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            logic v, inv;
            v   = ($urandom_range(0, 3) != 0);
            inv = 1'($urandom);
            rand_x(xr, xi);
            step(v, inv, xr, xi, $urandom_range(0, 3) != 0, model(xr, xi, inv), acc);
            if (acc) sent++;
        end
        check("random all sent", 72'(sent), 72'd10000);
        drain("random drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/r4_butterfly_pipe.md
Name: r4_butterfly_pipe

Overview:
- Parametrised, pipelined, fixed-point complex radix-4 DIT/DIF butterfly.
- Successor to the real-only floating-point butterfly test block:
  - full complex inputs;
  - per-transaction forward/inverse mode;
  - optional divide-by-4 scaling with rounding;
  - valid/ready handshake with backpressure.
- Sits between the FFT sample buffer and the twiddle-multiply stage.

Parameters:
- DW, 16, signed two's-complement width of each input real/imag component.
- SCALE, 0, 0 = full precision (OW = DW+2); 1 = outputs divided by 4 with rounding (OW = DW).
- OW, derived (SCALE ? DW : DW+2), width of each output component; not user-overridable.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline state
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- in_inv  in  1  0 = forward transform (-j rotation), 1 = inverse (+j rotation)
- x_re  in  4*DW  real parts; x0 in [DW-1:0], x1 next, ..., x3 in MSBs
- x_im  in  4*DW  imag parts, same packing
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts output this cycle
- y_re  out  4*OW  real parts y0..y3, y0 in LSBs
- y_im  out  4*OW  imag parts, same packing

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Two register stages, S1 and S2, each with valid bit v1/v2.
  - Enables: s2_en = ~v2 | out_ready; s1_en = ~v1 | s2_en; in_ready = s1_en (combinational).
  - S1 loads on s1_en: v1 <= in_valid; data loaded only when in_valid.
  - S2 loads on s2_en: v2 <= v1; data loaded only when v1.
- Latency: 2 cycles from input transfer to out_valid, when unstalled.
- Throughput: 1 transaction/cycle. No bubbles when out_ready is held high.
- Stage 1 arithmetic, sign-extended to DW+1 bits, complex:
  - a = x0+x2, b = x0-x2, c = x1+x3, d = x1-x3.
  - in_inv is registered alongside.
- Stage 2 arithmetic, DW+2 bits:
  - p = a+c, q = a-c.
  - r = (b.re+d.im, b.im-d.re), i.e. b - j*d.
  - s = (b.re-d.im, b.im+d.re), i.e. b + j*d.
- Output mapping:
  - Forward: y0 = p, y1 = r, y2 = q, y3 = s.
  - Inverse: y0 = p, y1 = s, y2 = q, y3 = r.
- SCALE=1: each component becomes (v + 2) >>> 2, arithmetic shift, truncated to DW bits.
  - This is round-half-up.
  - Provably no overflow: range [-2^(DW-1), 2^(DW-1)-1]. No saturation logic.
- SCALE=0: components are output unmodified at DW+2 bits, bit-exact.
- Outputs are registered, driven directly from S2.
- Stall:
  - While out_valid & ~out_ready, y_re/y_im/out_valid hold stable.
  - S1 holds if v1 is set.
  - in_ready drops only when both stages are full and out_ready = 0.
- Simultaneous events: when the pipe is full and out_ready = 1, the output transfer, S1->S2 advance and a new input transfer all occur in the same cycle.
- Reset:
  - Async assert clears v1, v2 and all data registers to 0.
  - out_valid = 0, y_re = 0, y_im = 0; in_ready = 1 once reset is low.
  - Reset mid-operation drops in-flight transactions; no partial output.
- in_inv, x_re and x_im are don't-care when in_valid = 0.

Test Plan:
- Forward, DW=16, SCALE=0, real x = {1,2,3,4}, imag 0 -> y0 = 10+0j, y1 = -2+2j, y2 = -2+0j, y3 = -2-2j; out_valid exactly 2 cycles after transfer.
- Same inputs with in_inv=1 -> y1 = -2-2j, y3 = -2+2j; y0 and y2 unchanged. Then alternate inv every cycle for 8 back-to-back transactions -> each output matches its own mode, no bubbles.
- SCALE=1 extremes:
  - All x.re = -32768 -> y0.re = -32768, all others 0.
  - All x.re = 32767 -> y0.re = 32767.
  - x0 = 2, rest 0 -> all y.re = 1.
  - x0 = 1 -> all y = 0.
- Backpressure:
  - Stream 6 transactions, out_ready=0 for cycles 3-7 -> in_ready low after 2 accepted; outputs held stable.
  - Release -> all 6 delivered in order, none lost or duplicated.
- Reset asserted asynchronously with v1 = v2 = 1 -> out_valid and outputs 0 immediately. After release: in_ready = 1, no stale output emerges.
- Random complex vectors (10k, both SCALE values) vs. golden DFT-4 model -> bit-exact match.
